// File: rtl/wide_add_pkg.sv
// Shared definitions for the multi-precision limb adder: limb width, FSM states
// and the limb-index width helper.
package wide_add_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Ceiling log2, used to size the limb index register.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// 16-bit carry-select adder used as the single limb adder of wide_add_sequencer.
// Four 4-bit blocks each precompute both carry-in cases and a mux picks one.
module Select_Carry_Adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    localparam int BLK    = 4;
    localparam int BLOCKS = 16 / BLK;

    logic [BLOCKS:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < BLOCKS; g++) begin : g_blk
        logic [BLK:0] res0;
        logic [BLK:0] res1;

        assign res0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign res1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + 5'd1;

        assign sum[g*BLK +: BLK] = carry[g] ? res1[BLK-1:0] : res0[BLK-1:0];
        assign carry[g+1]        = carry[g] ? res1[BLK]     : res0[BLK];
    end

    assign cout = carry[BLOCKS];

endmodule

// File: rtl/wide_add_sequencer.sv
// Sequential wide adder: accepts two WORDS-limb operands, adds one 16-bit limb per
// cycle through a single carry-select adder, then holds the result until taken.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [LIMB_W*WORDS-1:0]   a,
    input  logic [LIMB_W*WORDS-1:0]   b,
    input  logic                      carryIn,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [LIMB_W*WORDS-1:0]   sum,
    output logic                      carryOut,
    output logic                      overflow,
    output logic                      busy
);

    localparam int W  = LIMB_W * WORDS;
    localparam int IW = clog2(WORDS);

    state_t            state;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic              c_reg;
    logic [IW-1:0]     idx;

    logic [LIMB_W-1:0] limb_a;
    logic [LIMB_W-1:0] limb_b;
    logic [LIMB_W-1:0] limb_sum;
    logic              limb_cout;
    logic              last_limb;

    assign limb_a    = op_a[int'(idx)*LIMB_W +: LIMB_W];
    assign limb_b    = op_b[int'(idx)*LIMB_W +: LIMB_W];
    assign last_limb = (idx == IW'(WORDS - 1));

    Select_Carry_Adder u_limb_adder (
        .a    (limb_a),
        .b    (limb_b),
        .cin  (c_reg),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    // Handshake flags are registered next to the state so every output is a flop.
    // The sign bit of the result is the top bit of the final limb, so overflow is
    // decided on the same edge that stores that limb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            c_reg    <= 1'b0;
            sum      <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
            outValid <= 1'b0;
            busy     <= 1'b0;
            inReady  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        op_a     <= a;
                        op_b     <= b;
                        c_reg    <= carryIn;
                        idx      <= '0;
                        sum      <= '0;
                        carryOut <= 1'b0;
                        overflow <= 1'b0;
                        inReady  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(idx)*LIMB_W +: LIMB_W] <= limb_sum;
                    c_reg <= limb_cout;
                    if (last_limb) begin
                        carryOut <= limb_cout;
                        overflow <= (op_a[W-1] == op_b[W-1]) &&
                                    (limb_sum[LIMB_W-1] != op_a[W-1]);
                        busy     <= 1'b0;
                        outValid <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    outValid <= 1'b0;
                    busy     <= 1'b0;
                    inReady  <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed cases on a WORDS=4 instance,
// then randomized requests on WORDS=4 and WORDS=2 against a plain-arithmetic model.
module tb_wide_add_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        inValid4, inReady4, carryIn4, outValid4, outReady4;
    logic        carryOut4, overflow4, busy4;
    logic [63:0] a4, b4, sum4;

    logic        inValid2, inReady2, carryIn2, outValid2, outReady2;
    logic        carryOut2, overflow2, busy2;
    logic [31:0] a2, b2, sum2;

    int checkCount = 0;
    int passCount  = 0;

    wide_add_sequencer #(.WORDS(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid4),
        .inReady  (inReady4),
        .a        (a4),
        .b        (b4),
        .carryIn  (carryIn4),
        .outValid (outValid4),
        .outReady (outReady4),
        .sum      (sum4),
        .carryOut (carryOut4),
        .overflow (overflow4),
        .busy     (busy4)
    );

    wide_add_sequencer #(.WORDS(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid2),
        .inReady  (inReady2),
        .a        (a2),
        .b        (b2),
        .carryIn  (carryIn2),
        .outValid (outValid2),
        .outReady (outReady2),
        .sum      (sum2),
        .carryOut (carryOut2),
        .overflow (overflow2),
        .busy     (busy2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: {carryOut, sum} = a + b + carryIn over 16*words bits, overflow from sign bits.
    function automatic void refAdd(input int words, input logic [63:0] x, input logic [63:0] y,
                                   input logic c, output logic [63:0] s, output logic co,
                                   output logic ov);
        int          wb;
        logic [64:0] mask;
        logic [64:0] full;
        wb   = 16 * words;
        mask = (65'd1 << wb) - 65'd1;
        full = ({1'b0, x} & mask) + ({1'b0, y} & mask) + 65'(c);
        s    = 64'(full & mask);
        co   = full[wb];
        ov   = (x[wb-1] == y[wb-1]) && (s[wb-1] != x[wb-1]);
    endfunction

    function automatic logic [63:0] randomOperand(input int words);
        int          wb;
        logic [63:0] mask;
        logic [63:0] r;
        wb   = 16 * words;
        mask = (wb == 64) ? '1 : ((64'd1 << wb) - 64'd1);
        r    = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            0: r = mask;
            1: r = '0;
            2: r = mask >> 1;
            3: r = 64'd1 << (wb - 1);
            default: ;
        endcase
        return r & mask;
    endfunction

    task automatic send4(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                         input bit spam, output int waited);
        waited = 0;
        while (!inReady4 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) checkOutput("accept4_timeout", 64'd0, 64'd1);
        a4 = ta; b4 = tb; carryIn4 = tc; inValid4 = 1'b1;
        @(negedge clk);
        inValid4 = spam ? 1'($urandom) : 1'b0;
        a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom}; carryIn4 = 1'($urandom);
    endtask

    task automatic waitResult4(output int lat);
        lat = 0;
        while (!outValid4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!outValid4) checkOutput("result4_timeout", 64'd0, 64'd1);
    endtask

    task automatic send2(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
        int waited = 0;
        while (!inReady2 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) checkOutput("accept2_timeout", 64'd0, 64'd1);
        a2 = ta; b2 = tb; carryIn2 = tc; inValid2 = 1'b1;
        @(negedge clk);
        inValid2 = 1'($urandom);
        a2 = $urandom; b2 = $urandom; carryIn2 = 1'($urandom);
    endtask

    task automatic waitResult2(output int lat);
        lat = 0;
        while (!outValid2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!outValid2) checkOutput("result2_timeout", 64'd0, 64'd1);
    endtask

    // Directed request on the WORDS=4 instance; leaves the DUT in DONE.
    task automatic applyStimulus(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                                 input logic tc, output int waited);
        logic [63:0] es;
        logic        ec, eo;
        int          lat;
        refAdd(4, ta, tb, tc, es, ec, eo);
        send4(ta, tb, tc, 1'b0, waited);
        waitResult4(lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd4);
        checkOutput({tag, "_sum"}, sum4, es);
        checkOutput({tag, "_carryOut"}, 64'(carryOut4), 64'(ec));
        checkOutput({tag, "_overflow"}, 64'(overflow4), 64'(eo));
    endtask

    task automatic releaseResult4(input string tag);
        outReady4 = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_idle_outValid"}, 64'(outValid4), 64'd0);
        checkOutput({tag, "_idle_inReady"}, 64'(inReady4), 64'd1);
    endtask

    task automatic randomRun4(input int n);
        logic [63:0] ra, rb, es;
        logic        rc, ec, eo;
        int          hold, lat, waited;
        for (int i = 0; i < n; i++) begin
            ra = randomOperand(4); rb = randomOperand(4); rc = 1'($urandom);
            refAdd(4, ra, rb, rc, es, ec, eo);
            hold = $urandom_range(0, 3);
            outReady4 = (hold == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send4(ra, rb, rc, 1'b1, waited);
            waitResult4(lat);
            inValid4 = 1'b0;
            checkOutput("rnd4_latency", 64'(lat), 64'd4);
            checkOutput("rnd4_sum", sum4, es);
            checkOutput("rnd4_carryOut", 64'(carryOut4), 64'(ec));
            checkOutput("rnd4_overflow", 64'(overflow4), 64'(eo));
            for (int h = 0; h < hold; h++) begin
                inValid4 = 1'($urandom); a4 = {$urandom, $urandom};
                @(negedge clk);
                checkOutput("rnd4_hold_sum", sum4, es);
                checkOutput("rnd4_hold_outValid", 64'(outValid4), 64'd1);
            end
            inValid4 = 1'b0;
            outReady4 = 1'b1;
            @(negedge clk);
            checkOutput("rnd4_release_outValid", 64'(outValid4), 64'd0);
        end
    endtask

    task automatic randomRun2(input int n);
        logic [63:0] ra, rb, es;
        logic        rc, ec, eo;
        int          hold, lat;
        for (int i = 0; i < n; i++) begin
            ra = randomOperand(2); rb = randomOperand(2); rc = 1'($urandom);
            refAdd(2, ra, rb, rc, es, ec, eo);
            hold = $urandom_range(0, 3);
            outReady2 = (hold == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send2(ra[31:0], rb[31:0], rc);
            waitResult2(lat);
            inValid2 = 1'b0;
            checkOutput("rnd2_latency", 64'(lat), 64'd2);
            checkOutput("rnd2_sum", 64'(sum2), es);
            checkOutput("rnd2_carryOut", 64'(carryOut2), 64'(ec));
            checkOutput("rnd2_overflow", 64'(overflow2), 64'(eo));
            for (int h = 0; h < hold; h++) begin
                inValid2 = 1'($urandom); a2 = $urandom;
                @(negedge clk);
                checkOutput("rnd2_hold_sum", 64'(sum2), es);
                checkOutput("rnd2_hold_inReady", 64'(inReady2), 64'd0);
            end
            inValid2 = 1'b0;
            outReady2 = 1'b1;
            @(negedge clk);
            checkOutput("rnd2_release_inReady", 64'(inReady2), 64'd1);
        end
    endtask

    initial begin
        logic [63:0] es;
        logic        ec, eo;
        int          waited;

        inValid4 = 1'b0; a4 = '0; b4 = '0; carryIn4 = 1'b0; outReady4 = 1'b1;
        inValid2 = 1'b0; a2 = '0; b2 = '0; carryIn2 = 1'b0; outReady2 = 1'b1;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_outValid", 64'(outValid4), 64'd0);
        checkOutput("reset_inReady", 64'(inReady4), 64'd1);
        checkOutput("reset_busy", 64'(busy4), 64'd0);
        checkOutput("reset_sum", sum4, 64'd0);
        checkOutput("reset_carryOut", 64'(carryOut4), 64'd0);
        checkOutput("reset_overflow", 64'(overflow4), 64'd0);
        checkOutput("reset_inReady2", 64'(inReady2), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("no_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, waited);
        releaseResult4("no_carry");
        applyStimulus("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, waited);
        releaseResult4("ripple");
        applyStimulus("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, waited);
        releaseResult4("signed_ovf");

        // Backpressure: hold the result for ten cycles while poking inValid.
        outReady4 = 1'b0;
        applyStimulus("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, waited);
        refAdd(4, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, es, ec, eo);
        for (int i = 0; i < 10; i++) begin
            inValid4 = (i == 3);
            a4 = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("bp_outValid", 64'(outValid4), 64'd1);
            checkOutput("bp_sum_stable", sum4, es);
            checkOutput("bp_inReady", 64'(inReady4), 64'd0);
        end
        inValid4 = 1'b0;
        releaseResult4("bp");
        applyStimulus("bp_next", 64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAB, 1'b0, waited);
        checkOutput("bp_next_accept_wait", 64'(waited), 64'd0);
        releaseResult4("bp_next");

        // Reset in the middle of RUN, then a clean request.
        send4(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, waited);
        @(negedge clk);
        checkOutput("midrun_busy", 64'(busy4), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_sum", sum4, 64'd0);
        checkOutput("abort_carryOut", 64'(carryOut4), 64'd0);
        checkOutput("abort_overflow", 64'(overflow4), 64'd0);
        checkOutput("abort_outValid", 64'(outValid4), 64'd0);
        checkOutput("abort_busy", 64'(busy4), 64'd0);
        checkOutput("abort_inReady", 64'(inReady4), 64'd1);
        applyStimulus("after_abort", 64'h9249_2492_4924_9249, 64'h9249_2492_4924_9249, 1'b1, waited);
        releaseResult4("after_abort");

        randomRun4(500);
        randomRun2(500);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
